// File: rtl/p_clic_pkg.sv
// Shared types and default sizing for the core-local interrupt arbiter.
package p_clic_pkg;

    localparam int unsigned NrSourcesDef = 4;
    localparam int unsigned PrioWidthDef = 3;
    localparam int unsigned SrcWidthDef  = $clog2(NrSourcesDef);

    typedef logic [PrioWidthDef-1:0] prio_t;

    typedef struct packed {
        logic                   valid;
        prio_t                  prio;
        logic [SrcWidthDef-1:0] idx;
    } node_t;

endpackage

// File: rtl/p_clic_node.sv
// Two-input priority compare cell; the left operand (lower index) wins ties.
module p_clic_node
    import p_clic_pkg::*;
#(
    parameter int unsigned PrioWidth = PrioWidthDef,
    parameter int unsigned IdxWidth  = SrcWidthDef
) (
    input  logic                 valid_a_i,
    input  logic [PrioWidth-1:0] prio_a_i,
    input  logic [IdxWidth-1:0]  idx_a_i,
    input  logic                 valid_b_i,
    input  logic [PrioWidth-1:0] prio_b_i,
    input  logic [IdxWidth-1:0]  idx_b_i,
    output logic                 valid_c_o,
    output logic [PrioWidth-1:0] prio_c_o,
    output logic [IdxWidth-1:0]  idx_c_o
);

    logic take_b;

    // Right side wins only when strictly more urgent or the left is invalid.
    always_comb begin
        take_b    = valid_b_i && (!valid_a_i || (prio_b_i > prio_a_i));
        valid_c_o = valid_a_i | valid_b_i;
        prio_c_o  = '0;
        idx_c_o   = '0;
        if (take_b) begin
            prio_c_o = prio_b_i;
            idx_c_o  = idx_b_i;
        end else if (valid_a_i) begin
            prio_c_o = prio_a_i;
            idx_c_o  = idx_a_i;
        end
    end

endmodule

// File: rtl/p_clic_core.sv
// Core-local interrupt arbiter: picks the most urgent eligible source above
// the threshold through a binary compare tree and registers the winner.
module p_clic_core
    import p_clic_pkg::*;
#(
    parameter int unsigned NrSources = NrSourcesDef,
    parameter int unsigned PrioWidth = PrioWidthDef,
    localparam int unsigned SrcWidth = $clog2(NrSources)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NrSources-1:0] p,
    input  logic [NrSources-1:0] e,
    input  logic [PrioWidth-1:0] prio [NrSources],
    input  logic [PrioWidth-1:0] t,
    output logic [SrcWidth-1:0]  index,
    output logic                 is_interrupt
);

    localparam int unsigned NrLeaves = 1 << SrcWidth;
    localparam int unsigned NrNodes  = 2 * NrLeaves - 1;

    // Heap-ordered tree: node n has children 2n+1 and 2n+2, leaves at the end.
    logic                 tree_valid [NrNodes];
    logic [PrioWidth-1:0] tree_prio  [NrNodes];
    logic [SrcWidth-1:0]  tree_idx   [NrNodes];

    logic [SrcWidth-1:0] index_d, index_q;
    logic                irq_d, irq_q;

    for (genvar i = 0; i < NrLeaves; i++) begin : g_leaf
        if (i < NrSources) begin : g_real
            assign tree_valid[NrLeaves-1+i] = p[i] & e[i] & (prio[i] > t);
            assign tree_prio[NrLeaves-1+i]  = prio[i];
            assign tree_idx[NrLeaves-1+i]   = SrcWidth'(i);
        end else begin : g_pad
            assign tree_valid[NrLeaves-1+i] = 1'b0;
            assign tree_prio[NrLeaves-1+i]  = '0;
            assign tree_idx[NrLeaves-1+i]   = '0;
        end
    end

    for (genvar n = 0; n < NrLeaves - 1; n++) begin : g_node
        p_clic_node #(
            .PrioWidth (PrioWidth),
            .IdxWidth  (SrcWidth)
        ) u_node (
            .valid_a_i (tree_valid[2*n+1]),
            .prio_a_i  (tree_prio[2*n+1]),
            .idx_a_i   (tree_idx[2*n+1]),
            .valid_b_i (tree_valid[2*n+2]),
            .prio_b_i  (tree_prio[2*n+2]),
            .idx_b_i   (tree_idx[2*n+2]),
            .valid_c_o (tree_valid[n]),
            .prio_c_o  (tree_prio[n]),
            .idx_c_o   (tree_idx[n])
        );
    end

    always_comb begin
        index_d = '0;
        irq_d   = tree_valid[0];
        if (tree_valid[0]) begin
            index_d = tree_idx[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            index_q <= index_d;
            irq_q   <= irq_d;
        end
    end

    assign index        = index_q;
    assign is_interrupt = irq_q;

endmodule

// File: tb/tb_p_clic_core.sv
// Directed and random checks of p_clic_core against a behavioural arbiter model.
module tb_p_clic_core;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 3;
    localparam int unsigned SW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  p;
    logic [N-1:0]  e;
    logic [PW-1:0] prio [N];
    logic [PW-1:0] t;
    logic [SW-1:0] index;
    logic          is_interrupt;

    int compared   = 0;
    int mismatched = 0;

    p_clic_core #(
        .NrSources (N),
        .PrioWidth (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p            (p),
        .e            (e),
        .prio         (prio),
        .t            (t),
        .index        (index),
        .is_interrupt (is_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan all sources; a later source replaces the best only when strictly more urgent.
    function automatic void model(output logic [SW-1:0] exp_idx, output logic exp_irq);
        int best   = -1;
        int best_p = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (p[i] && e[i] && (int'(prio[i]) > int'(t))) begin
                if (best < 0 || int'(prio[i]) > best_p) begin
                    best   = i;
                    best_p = int'(prio[i]);
                end
            end
        end
        exp_irq = (best >= 0);
        exp_idx = (best >= 0) ? SW'(best) : '0;
    endfunction

    task automatic check(input string tag, input logic [SW-1:0] exp_idx, input logic exp_irq);
        compared++;
        assert (is_interrupt === exp_irq) else begin
            mismatched++;
            $error("FAIL %s is_interrupt observed=%0b expected=%0b", tag, is_interrupt, exp_irq);
        end
        compared++;
        assert (index === exp_idx) else begin
            mismatched++;
            $error("FAIL %s index observed=%0d expected=%0d", tag, index, exp_idx);
        end
    endtask

    task automatic drive(input logic [N-1:0] pv, input logic [N-1:0] ev,
                         input int p0, input int p1, input int p2, input int p3,
                         input logic [PW-1:0] tv);
        p       = pv;
        e       = ev;
        prio[0] = PW'(p0);
        prio[1] = PW'(p1);
        prio[2] = PW'(p2);
        prio[3] = PW'(p3);
        t       = tv;
    endtask

    // Apply inputs, take one edge, compare to the model and to the plan's stated result.
    task automatic step(input string tag, input logic [N-1:0] pv, input logic [N-1:0] ev,
                        input int p0, input int p1, input int p2, input int p3,
                        input logic [PW-1:0] tv, input logic [SW-1:0] plan_idx,
                        input logic plan_irq);
        logic [SW-1:0] m_idx;
        logic          m_irq;
        drive(pv, ev, p0, p1, p2, p3, tv);
        model(m_idx, m_irq);
        @(posedge clk);
        #1;
        check(tag, plan_idx, plan_irq);
        check({tag, "_model"}, m_idx, m_irq);
    endtask

    initial begin
        logic [SW-1:0] m_idx;
        logic          m_irq;

        rst = 1'b1;
        drive('1, '1, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        check("reset_hold", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-run with an eligible source.
        drive('1, '1, 0, 4, 0, 0, '0);
        @(posedge clk);
        #1;
        check("pre_reset", 2'd1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", '0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_released_no_edge", '0, 1'b0);
        @(posedge clk);
        #1;
        check("first_after_reset", 2'd1, 1'b1);

        step("all_zero",  '1, '1, 0, 0, 0, 0, 3'd0, 2'd0, 1'b0);
        step("p0001",     '1, '1, 0, 0, 0, 1, 3'd0, 2'd3, 1'b1);
        step("p0011",     '1, '1, 0, 0, 1, 1, 3'd0, 2'd2, 1'b1);
        step("p0111",     '1, '1, 0, 1, 1, 1, 3'd0, 2'd1, 1'b1);
        step("p1111",     '1, '1, 1, 1, 1, 1, 3'd0, 2'd0, 1'b1);
        step("t6",        '1, '1, 5, 2, 7, 7, 3'd6, 2'd2, 1'b1);
        step("t7",        '1, '1, 5, 2, 7, 7, 3'd7, 2'd0, 1'b0);
        step("t6_e1011",  '1, 4'b1011, 5, 2, 7, 7, 3'd6, 2'd3, 1'b1);
        step("t6_p0011",  4'b0011, '1, 5, 2, 7, 7, 3'd6, 2'd0, 1'b0);
        step("max_prio",  '1, '1, 7, 7, 7, 7, 3'd6, 2'd0, 1'b1);

        // Random back-to-back traffic against the model.
        for (int k = 0; k < 300; k++) begin
            p = N'($urandom);
            e = N'($urandom);
            for (int i = 0; i < int'(N); i++) prio[i] = PW'($urandom);
            t = ($urandom_range(0, 3) == 0) ? '0 : PW'($urandom);
            model(m_idx, m_irq);
            @(posedge clk);
            #1;
            check("random", m_idx, m_irq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
